// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: I-cache line to Fetch0 instruction queue.
// Enqueues the tail of a fetch line; in-order variable-width dequeue window.
module fetch_inst_buffer #(
  parameter int DEPTH       = 32,
  parameter int FETCH_WIDTH = 16,
  parameter int READ_WIDTH  = 2,
  parameter int PC_W        = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              fetch_valid_i,
  output logic                              fetch_ready_o,
  input  logic [PC_W-1:0]                   fetch_pc_i,
  input  logic [FETCH_WIDTH*32-1:0]         fetch_data_i,
  output logic [READ_WIDTH-1:0]             deq_vld_o,
  output logic [READ_WIDTH*PC_W-1:0]        deq_pc_o,
  output logic [READ_WIDTH*32-1:0]          deq_inst_o,
  input  logic [$clog2(READ_WIDTH+1)-1:0]   deq_cnt_i,
  input  logic                              flush_i,
  output logic [$clog2(DEPTH+1)-1:0]        count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(FETCH_WIDTH);
  localparam int LW = FETCH_WIDTH*32;

  logic [31:0]     inst_q [DEPTH];
  logic [PC_W-1:0] pc_q   [DEPTH];
  logic [AW-1:0]   head_q;
  logic [AW-1:0]   tail_q;
  logic [CW-1:0]   count_q;
  logic [OW-1:0]   off;
  logic [CW-1:0]   n_enq;
  logic [LW-1:0]   line_sh;
  logic            enq_fire;

  assign off      = fetch_pc_i[OW+1:2];
  assign n_enq    = CW'(FETCH_WIDTH) - CW'(off);
  assign line_sh  = fetch_data_i >> {off, 5'b0};

  // Ready reserves room for a whole line, independent of the offset.
  assign fetch_ready_o = count_q <= CW'(DEPTH - FETCH_WIDTH);
  assign enq_fire = fetch_valid_i && fetch_ready_o && !flush_i;
  assign count_o  = count_q;

  // Write the wanted part of the line, each slot tagged with its own PC.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (CW'(j) < n_enq) begin
          inst_q[tail_q + AW'(j)] <= line_sh[j*32 +: 32];
          pc_q[tail_q + AW'(j)]   <= fetch_pc_i + PC_W'(4*j);
        end
      end
    end
  end

  // Pointers and occupancy; flush beats enqueue and dequeue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + AW'(deq_cnt_i);
      if (enq_fire)
        tail_q <= tail_q + AW'(n_enq);
      count_q <= count_q + (enq_fire ? n_enq : '0)
               - CW'(deq_cnt_i);
    end
  end

  // Head window: slot s is the s-th oldest entry.
  always_comb begin
    deq_vld_o  = '0;
    deq_inst_o = '0;
    deq_pc_o   = '0;
    for (int s = 0; s < READ_WIDTH; s++) begin
      deq_vld_o[s] = CW'(s) < count_q;
      deq_inst_o[s*32 +: 32]   = inst_q[head_q + AW'(s)];
      deq_pc_o[s*PC_W +: PC_W] = pc_q[head_q + AW'(s)];
    end
  end

  a_deq_legal: assert property (
    @(posedge clk) disable iff (!rst_n || flush_i)
    32'(deq_cnt_i) <= $countones(deq_vld_o));

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// tb_fetch_inst_buffer: directed checks of fetch_inst_buffer.
// Defaults: DEPTH 32, FETCH_WIDTH 16, READ_WIDTH 2, PC_W 64.
module tb_fetch_inst_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fetch_valid;
  logic         fetch_ready;
  logic [63:0]  fetch_pc;
  logic [511:0] fetch_data;
  logic [1:0]   deq_vld;
  logic [127:0] deq_pc;
  logic [63:0]  deq_inst;
  logic [1:0]   deq_cnt;
  logic         flush;
  logic [5:0]   count;

  int total = 0;
  int bad   = 0;

  fetch_inst_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_valid_i (fetch_valid),
    .fetch_ready_o (fetch_ready),
    .fetch_pc_i    (fetch_pc),
    .fetch_data_i  (fetch_data),
    .deq_vld_o     (deq_vld),
    .deq_pc_o      (deq_pc),
    .deq_inst_o    (deq_inst),
    .deq_cnt_i     (deq_cnt),
    .flush_i       (flush),
    .count_o       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [63:0] pc, input logic [31:0] base,
                       input logic [31:0] inc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    for (int k = 0; k < 16; k++)
      fetch_data[k*32 +: 32] = base + inc * k;
  endtask

  initial begin : main
    logic [63:0] exp_pc;
    logic [63:0] nxt;
    int          mcnt;
    int          d;
    logic        en;
    logic        done;

    rst_n = 1'b0;
    fetch_valid = 1'b0;
    fetch_pc = '0;
    fetch_data = '0;
    deq_cnt = '0;
    flush = 1'b0;
    #12;
    check("rst_count", 64'(count), 0);
    check("rst_vld", 64'(deq_vld), 0);
    check("rst_ready", 64'(fetch_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // full line at 0x1000
    offer(64'h1000, 32'h100, 1);
    tick();
    fetch_valid = 1'b0;
    check("l0_count", 64'(count), 16);
    check("l0_vld", 64'(deq_vld), 3);
    check("l0_inst0", 64'(deq_inst[31:0]), 64'h100);
    check("l0_pc0", deq_pc[63:0], 64'h1000);
    check("l0_inst1", 64'(deq_inst[63:32]), 64'h101);
    check("l0_pc1", deq_pc[127:64], 64'h1004);
    for (int i = 0; i < 8; i++) begin
      check("l0_drain_pc", deq_pc[63:0], 64'h1000 + 64'(8*i));
      deq_cnt = 2'd2;
      tick();
    end
    deq_cnt = 2'd0;
    check("l0_empty", 64'(count), 0);
    check("l0_empty_vld", 64'(deq_vld), 0);

    // offset 14 line: only two instructions
    offer(64'h2038, 32'h200, 1);
    tick();
    fetch_valid = 1'b0;
    check("off_count", 64'(count), 2);
    check("off_vld", 64'(deq_vld), 3);
    check("off_pc0", deq_pc[63:0], 64'h2038);
    check("off_inst0", 64'(deq_inst[31:0]), 64'h20E);
    check("off_pc1", deq_pc[127:64], 64'h203C);
    check("off_inst1", 64'(deq_inst[63:32]), 64'h20F);
    deq_cnt = 2'd2;
    tick();
    deq_cnt = 2'd0;
    check("off_count2", 64'(count), 0);
    check("off_vld2", 64'(deq_vld), 0);

    // fill to DEPTH
    offer(64'h3000, 32'h3000, 4);
    tick();
    check("fill_c16", 64'(count), 16);
    check("fill_rdy16", 64'(fetch_ready), 1);
    offer(64'h3040, 32'h3040, 4);
    tick();
    check("fill_c32", 64'(count), 32);
    check("fill_rdy32", 64'(fetch_ready), 0);
    offer(64'h4000, 32'h4000, 4);
    tick();
    fetch_valid = 1'b0;
    check("fill_blocked", 64'(count), 32);
    check("fill_head", deq_pc[63:0], 64'h3000);
    deq_cnt = 2'd2;
    for (int i = 0; i < 8; i++) tick();
    deq_cnt = 2'd0;
    check("fill_c16b", 64'(count), 16);
    check("fill_rdy16b", 64'(fetch_ready), 1);
    check("fill_headb", deq_pc[63:0], 64'h3040);
    check("fill_instb", 64'(deq_inst[31:0]), 64'h3040);

    // stream across the pointer wrap
    mcnt = 16;
    exp_pc = 64'h3040;
    nxt = 64'h3080;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      check("wrap_cnt", 64'(count), 64'(mcnt));
      check("wrap_rdy", 64'(fetch_ready), 64'(mcnt <= 16));
      if (mcnt > 0) begin
        check("wrap_pc0", deq_pc[63:0], exp_pc);
        check("wrap_inst0", 64'(deq_inst[31:0]), 64'(exp_pc[31:0]));
      end
      if (mcnt > 1)
        check("wrap_pc1", deq_pc[127:64], exp_pc + 4);
      en = (mcnt <= 16) && (nxt < 64'h3100);
      if (en) offer(nxt, nxt[31:0], 4);
      else fetch_valid = 1'b0;
      d = (mcnt >= 2) ? 2 : mcnt;
      deq_cnt = 2'(d);
      tick();
      mcnt = mcnt + (en ? 16 : 0) - d;
      exp_pc = exp_pc + 64'(4*d);
      if (en) nxt = nxt + 64'h40;
      if (mcnt == 0 && nxt == 64'h3100) done = 1'b1;
    end
    fetch_valid = 1'b0;
    deq_cnt = 2'd0;
    check("wrap_done", 64'(done), 1);
    check("wrap_empty", 64'(count), 0);

    // simultaneous enqueue and dequeue
    offer(64'h5034, 32'h5000, 4);
    tick();
    fetch_valid = 1'b0;
    check("sim_c3", 64'(count), 3);
    check("sim_pc0", deq_pc[63:0], 64'h5034);
    check("sim_inst0", 64'(deq_inst[31:0]), 64'h5034);
    offer(64'h5040, 32'h5040, 4);
    deq_cnt = 2'd1;
    tick();
    fetch_valid = 1'b0;
    check("sim_c18", 64'(count), 18);
    check("sim_head", deq_pc[63:0], 64'h5038);
    check("sim_inst", 64'(deq_inst[31:0]), 64'h5038);
    check("sim_rdy18", 64'(fetch_ready), 0);
    tick();
    check("bnd_c17", 64'(count), 17);
    check("bnd_rdy17", 64'(fetch_ready), 0);
    offer(64'h603C, 32'h6000, 4);
    tick();
    fetch_valid = 1'b0;
    deq_cnt = 2'd0;
    check("bnd_c16", 64'(count), 16);
    check("bnd_rdy16", 64'(fetch_ready), 1);
    check("bnd_head", deq_pc[63:0], 64'h5040);

    // flush beats enqueue and dequeue
    offer(64'h6000, 32'h6000, 4);
    deq_cnt = 2'd2;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch_valid = 1'b0;
    deq_cnt = 2'd0;
    check("fl_count", 64'(count), 0);
    check("fl_vld", 64'(deq_vld), 0);
    check("fl_rdy", 64'(fetch_ready), 1);
    offer(64'h7008, 32'h7000, 4);
    tick();
    fetch_valid = 1'b0;
    check("fl_c14", 64'(count), 14);
    check("fl_pc0", deq_pc[63:0], 64'h7008);
    check("fl_inst0", 64'(deq_inst[31:0]), 64'h7008);
    check("fl_head", 64'(dut.head_q), 0);
    check("fl_tail", 64'(dut.tail_q), 14);

    // asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count", 64'(count), 0);
    check("ar_vld", 64'(deq_vld), 0);
    check("ar_rdy", 64'(fetch_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    offer(64'h8000, 32'h8000, 4);
    tick();
    fetch_valid = 1'b0;
    check("ar_c16", 64'(count), 16);
    check("ar_pc0", deq_pc[63:0], 64'h8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
